alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Decode/issue pipeline stage that sits directly upstream of the ALU.
//  Accepts a Beta-format instruction plus regfile read data, applies R31-zero and
//  one-source forwarding, builds the 6-bit alufn and 32-bit a/b operands, and
//  registers them behind a valid/ready handshake with a 2-entry skid buffer, so
//  the ALU sees only registered, stable inputs.
// PARAMETERS
//  DATA_W   32  operand/result width (only 32 is supported)
//  SKID_EN  1   1: 2-entry skid (in_ready registered); 0: single register, in_ready = out_ready | ~out_valid
// PORTS
//  clk        in   1   rising-edge clock
//  reset_n    in   1   asynchronous active-low reset
//  in_valid   in   1   instr/ra_data/rb_data valid
//  in_ready   out  1   stage can accept; transfer when in_valid & in_ready
//  instr      in   32  [31:26] opcode, [25:21] rc, [20:16] ra, [15:11] rb, [15:0] literal
//  ra_data    in   32  regfile read of instr[20:16]
//  rb_data    in   32  regfile read of instr[15:11]
//  fwd_valid  in   1   writeback bypass valid
//  fwd_reg    in   5   writeback destination register
//  fwd_data   in   32  writeback value
//  out_valid  out  1   alufn/a/b/rc/illegal valid toward ALU
//  out_ready  in   1   ALU/execute consumes; transfer when out_valid & out_ready
//  alufn      out  6   ALU function code
//  a          out  32  operand A
//  b          out  32  operand B
//  rc         out  5   destination register, passed through
//  illegal    out  1   opcode not in the supported table
// BEHAVIOUR
//  Reset (async, reset_n=0): out_valid=0, in_ready=0 while asserted, then 1 on first clk; alufn/a/b/rc=0; illegal=0; skid empty.
//  Latency: accepted instr appears on outputs the cycle after in_valid&in_ready. Throughput 1/clk when out_ready=1.
//  Opcode -> alufn (op[5:4]=10 reg-reg; 11 literal, with the same op[3:0] table):
//   0 ADD 000000 | 1 SUB 000001 | 4 CMPEQ 110011 | 5 CMPLT 110101 | 6 CMPLE 110111
//   8 AND 011000 | 9 OR 011110 | A XOR 010110 | B XNOR 011001
//   C SHL 100000 | D SHR 100001 | E SRA 100011 | others (incl. MUL=2, DIV=3): illegal=1, alufn=000000
//  op[5:4] not 1x: illegal=1, alufn=000000, a=b=0; still transferred, never dropped.
//  Operand A: ra==31 -> 0; else fwd_valid & fwd_reg==ra -> fwd_data; else ra_data.
//  Operand B: literal form -> sign-extended instr[15:0]; else same rule as A for rb.
//  Forwarding sampled in the accepting cycle only; fwd_reg==31 never forwards.
//  Skid (SKID_EN=1): main reg drives outputs; in_ready = ~skid_full (registered).
//   Accept while out stalled & main full -> write skid; skid_full=1 -> in_ready=0 next clk.
//   On out handshake: skid -> main if skid full, else accepted input -> main, else out_valid=0.
//   Simultaneous accept + output handshake with skid empty: main reloads, out_valid stays 1.
//   Outputs hold stable while out_valid & ~out_ready (no change of any output field).
//  Ordering strictly FIFO; max 2 in flight; no entry lost or duplicated.
//  Reset mid-operation: both entries discarded, out_valid drops asynchronously.
// TESTING
//  ADD r1,r2,r3 (instr 0x80221800), ra=5, rb=7 -> next clk alufn=00, a=5, b=7, rc=1.
//  ADDC r1,r2,-1 (0xC022FFFF), ra=3 -> b=0xFFFFFFFF, alufn=00; CMPLEC -> alufn=37 (6'b110111).
//  ra=31, rb=31 -> a=b=0 even with ra_data=0xDEADBEEF; fwd_reg=2, fwd_valid, ra=2 -> a=fwd_data.
//  out_ready=0, push 3 back-to-back -> first on outputs, second in skid, in_ready=0; third held.
//  Release out_ready -> outputs in order 1,2,3 on consecutive clks, none duplicated.
//  MUL (0x88...) -> illegal=1, alufn=00; reset_n low while out_valid=1 -> out_valid=0 immediately.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the Beta ALU: decodes opcode to alufn, builds forwarded
// A/B operands and registers them behind a valid/ready handshake with an optional 2-entry skid.
module alu_operand_stage #(
    parameter int DATA_W  = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] ra_data,
    input  logic [DATA_W-1:0] rb_data,
    input  logic              fwd_valid,
    input  logic [4:0]        fwd_reg,
    input  logic [DATA_W-1:0] fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        alufn,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [4:0]        rc,
    output logic              illegal
);

    typedef struct packed {
        logic [5:0]        alufn;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [4:0]        rc;
        logic              illegal;
    } entry_t;

    localparam logic [4:0] R31 = 5'd31;

    logic [5:0] op;
    logic [4:0] ra_idx;
    logic [4:0] rb_idx;
    entry_t     in_entry;

    // R31 always reads as zero, which also keeps a fwd_reg of 31 from ever forwarding.
    function automatic logic [DATA_W-1:0] pick_operand(
        input logic [4:0]        idx,
        input logic [DATA_W-1:0] rf_data,
        input logic              byp_valid,
        input logic [4:0]        byp_reg,
        input logic [DATA_W-1:0] byp_data
    );
        if (idx == R31)
            return '0;
        else if (byp_valid && (byp_reg == idx))
            return byp_data;
        else
            return rf_data;
    endfunction

    assign op     = instr[31:26];
    assign ra_idx = instr[20:16];
    assign rb_idx = instr[15:11];

    always_comb begin
        // NOTE: every field gets a default before the branches so no latch is inferred.
        in_entry    = '0;
        in_entry.rc = instr[25:21];
        if (op[5]) begin
            in_entry.a = pick_operand(ra_idx, ra_data, fwd_valid, fwd_reg, fwd_data);
            if (op[4])
                in_entry.b = {{(DATA_W-16){instr[15]}}, instr[15:0]};
            else
                in_entry.b = pick_operand(rb_idx, rb_data, fwd_valid, fwd_reg, fwd_data);
            unique case (op[3:0])
                4'h0:    in_entry.alufn = 6'b000000;
                4'h1:    in_entry.alufn = 6'b000001;
                4'h4:    in_entry.alufn = 6'b110011;
                4'h5:    in_entry.alufn = 6'b110101;
                4'h6:    in_entry.alufn = 6'b110111;
                4'h8:    in_entry.alufn = 6'b011000;
                4'h9:    in_entry.alufn = 6'b011110;
                4'hA:    in_entry.alufn = 6'b010110;
                4'hB:    in_entry.alufn = 6'b011001;
                4'hC:    in_entry.alufn = 6'b100000;
                4'hD:    in_entry.alufn = 6'b100001;
                4'hE:    in_entry.alufn = 6'b100011;
                default: in_entry.illegal = 1'b1;
            endcase
        end else begin
            in_entry.illegal = 1'b1;
        end
    end

    entry_t main_q, main_d;
    entry_t skid_q;
    logic   main_valid_q, main_valid_d;
    logic   skid_full_q, skid_full_d;
    logic   skid_load;
    logic   rdy_en_q;
    logic   accept;
    logic   out_hs;

    assign accept = in_valid & in_ready;
    assign out_hs = main_valid_q & out_ready;

    generate
        if (SKID_EN) begin : g_skid_ready
            assign in_ready = rdy_en_q & ~skid_full_q;
        end else begin : g_pass_ready
            assign in_ready = rdy_en_q & (out_ready | ~main_valid_q);
        end
    endgenerate

    // The skid entry only ever fills while main is full and stalled, so
    // draining it into main on the next output handshake keeps FIFO order.
    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_full_d  = skid_full_q;
        skid_load    = 1'b0;
        if (out_hs) begin
            if (skid_full_q) begin
                main_d      = skid_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                main_d = in_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q) begin
                main_d       = in_entry;
                main_valid_d = 1'b1;
            end else if (SKID_EN) begin
                skid_load   = 1'b1;
                skid_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset_n) begin
            main_q       <= '0;
            main_valid_q <= 1'b0;
            skid_full_q  <= 1'b0;
            rdy_en_q     <= 1'b0;
        end else begin
            main_q       <= main_d;
            main_valid_q <= main_valid_d;
            skid_full_q  <= skid_full_d;
            rdy_en_q     <= 1'b1;
        end
    end

    // NOTE: the skid payload has no reset; it is never observed unless skid_full_q is set.
    always_ff @(posedge clk) begin
        if (skid_load)
            skid_q <= in_entry;
    end

    assign out_valid = main_valid_q;
    assign alufn     = main_q.alufn;
    assign a         = main_q.a;
    assign b         = main_q.b;
    assign rc        = main_q.rc;
    assign illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: decode, forwarding, R31, skid stall/drain and reset.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  alufn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rc;
    logic        illegal;

    int tests = 0;
    int fails = 0;

    alu_operand_stage #(.DATA_W(32), .SKID_EN(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .ra_data   (ra_data),
        .rb_data   (rb_data),
        .fwd_valid (fwd_valid),
        .fwd_reg   (fwd_reg),
        .fwd_data  (fwd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alufn     (alufn),
        .a         (a),
        .b         (b),
        .rc        (rc),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] rad, input logic [31:0] rbd);
        in_valid = 1'b1;
        instr    = ins;
        ra_data  = rad;
        rb_data  = rbd;
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        ra_data   = '0;
        rb_data   = '0;
        fwd_valid = 1'b0;
        fwd_reg   = '0;
        fwd_data  = '0;
        out_ready = 1'b1;

        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_alufn",     {26'd0, alufn},     32'd0);
        chk("rst_a",         a,                  32'd0);
        chk("rst_b",         b,                  32'd0);
        chk("rst_rc",        {27'd0, rc},        32'd0);
        chk("rst_illegal",   {31'd0, illegal},   32'd0);
        #1 reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD r1,r2,r3
        drive(32'h80221800, 32'd5, 32'd7);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_alufn", {26'd0, alufn},     32'h00);
        chk("add_a",     a,                  32'd5);
        chk("add_b",     b,                  32'd7);
        chk("add_rc",    {27'd0, rc},        32'd1);
        chk("add_ill",   {31'd0, illegal},   32'd0);

        // ADDC r1,r2,-1 reloads main while the ADD is consumed
        drive(32'hC022FFFF, 32'd3, 32'h5555_5555);
        tick();
        chk("addc_valid", {31'd0, out_valid}, 32'd1);
        chk("addc_alufn", {26'd0, alufn},     32'h00);
        chk("addc_a",     a,                  32'd3);
        chk("addc_b",     b,                  32'hFFFF_FFFF);

        // CMPLEC r4,r5,10
        drive({6'h36, 5'd4, 5'd5, 16'h000A}, 32'h0000_0100, 32'hAAAA_AAAA);
        tick();
        chk("cmplec_alufn", {26'd0, alufn}, 32'h37);
        chk("cmplec_a",     a,              32'h0000_0100);
        chk("cmplec_b",     b,              32'h0000_000A);
        chk("cmplec_rc",    {27'd0, rc},    32'd4);

        // SUB r3,r31,r31 with a bypass aimed at r31: both operands must still be zero
        fwd_valid = 1'b1;
        fwd_reg   = 5'd31;
        fwd_data  = 32'h0000_1234;
        drive({6'h21, 5'd3, 5'd31, 5'd31, 11'd0}, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        tick();
        chk("r31_alufn", {26'd0, alufn}, 32'h01);
        chk("r31_a",     a,              32'd0);
        chk("r31_b",     b,              32'd0);

        // ADD r5,r2,r6 with bypass on ra
        fwd_reg  = 5'd2;
        fwd_data = 32'hCAFE_0001;
        drive({6'h20, 5'd5, 5'd2, 5'd6, 11'd0}, 32'h0000_0011, 32'h0000_0022);
        tick();
        chk("fwd_ra_a", a, 32'hCAFE_0001);
        chk("fwd_ra_b", b, 32'h0000_0022);

        // XOR r7,r8,r9 with bypass on rb
        fwd_reg  = 5'd9;
        fwd_data = 32'h0BAD_F00D;
        drive({6'h2A, 5'd7, 5'd8, 5'd9, 11'd0}, 32'h0000_0033, 32'h0000_0044);
        tick();
        chk("fwd_rb_alufn", {26'd0, alufn}, 32'h16);
        chk("fwd_rb_a",     a,              32'h0000_0033);
        chk("fwd_rb_b",     b,              32'h0BAD_F00D);
        fwd_valid = 1'b0;

        // Bypass only matters in the accepting cycle: fwd changes afterwards must not leak
        drive({6'h20, 5'd6, 5'd2, 5'd3, 11'd0}, 32'h0000_0077, 32'h0000_0088);
        tick();
        fwd_valid = 1'b1;
        fwd_reg   = 5'd2;
        fwd_data  = 32'hFFFF_0000;
        chk("nofwd_a", a, 32'h0000_0077);
        fwd_valid = 1'b0;

        // MUL r1,r2,r3 is not supported
        drive(32'h88221800, 32'd1, 32'd2);
        tick();
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_ill",   {31'd0, illegal},   32'd1);
        chk("mul_alufn", {26'd0, alufn},     32'h00);

        // Opcode outside 1x group: illegal, zero operands, still transferred
        drive({6'h05, 5'd2, 5'd1, 5'd1, 11'd0}, 32'h1111_1111, 32'h2222_2222);
        tick();
        chk("op0x_valid", {31'd0, out_valid}, 32'd1);
        chk("op0x_ill",   {31'd0, illegal},   32'd1);
        chk("op0x_a",     a,                  32'd0);
        chk("op0x_b",     b,                  32'd0);
        chk("op0x_rc",    {27'd0, rc},        32'd2);

        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Stall: three AND instructions pushed back-to-back with out_ready low
        out_ready = 1'b0;
        drive({6'h28, 5'd1, 5'd1, 5'd2, 11'd0}, 32'h0000_00A1, 32'h0000_00B1);
        tick();
        chk("e1_valid",    {31'd0, out_valid}, 32'd1);
        chk("e1_rc",       {27'd0, rc},        32'd1);
        chk("e1_alufn",    {26'd0, alufn},     32'h18);
        chk("e1_in_ready", {31'd0, in_ready},  32'd1);
        drive({6'h28, 5'd2, 5'd1, 5'd2, 11'd0}, 32'h0000_00A2, 32'h0000_00B2);
        tick();
        chk("e2_in_ready", {31'd0, in_ready}, 32'd0);
        chk("e2_hold_rc",  {27'd0, rc},       32'd1);
        chk("e2_hold_a",   a,                 32'h0000_00A1);
        drive({6'h28, 5'd3, 5'd1, 5'd2, 11'd0}, 32'h0000_00A3, 32'h0000_00B3);
        tick();
        chk("e3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("e3_hold_rc",  {27'd0, rc},       32'd1);
        chk("e3_hold_b",   b,                 32'h0000_00B1);
        tick();
        chk("e3_hold2_rc", {27'd0, rc},       32'd1);

        // Release: expect 2 then 3 on consecutive clocks
        out_ready = 1'b1;
        tick();
        chk("rel_rc2",       {27'd0, rc},       32'd2);
        chk("rel_a2",        a,                 32'h0000_00A2);
        chk("rel_in_ready",  {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("rel_rc3",       {27'd0, rc},       32'd3);
        chk("rel_a3",        a,                 32'h0000_00A3);
        chk("rel_valid3",    {31'd0, out_valid}, 32'd1);
        tick();
        chk("rel_empty",     {31'd0, out_valid}, 32'd0);

        // Reset while an entry is waiting on the output
        out_ready = 1'b0;
        drive({6'h29, 5'd9, 5'd1, 5'd2, 11'd0}, 32'h0000_0055, 32'h0000_0066);
        tick();
        in_valid = 1'b0;
        chk("mid_valid_pre", {31'd0, out_valid}, 32'd1);
        chk("mid_alufn_pre", {26'd0, alufn},     32'h1E);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_valid_rst", {31'd0, out_valid}, 32'd0);
        chk("mid_ready_rst", {31'd0, in_ready},  32'd0);
        chk("mid_a_rst",     a,                  32'd0);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("mid_ready_post", {31'd0, in_ready},  32'd1);
        chk("mid_valid_post", {31'd0, out_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
